// File: rtl/ttc_intr_sched19.sv
// ttc_intr_sched19: three-channel timer interrupt scheduler with ack/clear handshake,
// fixed or round-robin arbitration, and an optional acknowledge timeout.
module ttc_intr_sched19 #(
  parameter logic [7:0] ACK_TIMEOUT = 8'd200,
  parameter int         HOLDOFF     = 2
) (
  input  logic       pclk19,
  input  logic       n_p_reset19,
  input  logic [2:0] chan_intr19,
  input  logic       cfg_sel19,
  input  logic [7:0] pwdata19,
  input  logic       ack19,
  output logic       irq19,
  output logic [1:0] irq_id19,
  output logic [2:0] clear_interrupt19,
  output logic [4:0] cfg_out19,
  output logic       timeout_flag19
);
  typedef enum logic [1:0] {IDLE, ASSERT, CLEAR, HOLD} state_t;
  state_t     state;
  logic [1:0] id, last_grant, grant, c0, c1, c2;
  logic [7:0] ack_cnt;
  logic [2:0] hold_cnt;
  logic [3:0] elig;
  logic       en_next, timeout, unused_bits;
  function automatic logic [1:0] nxt(input logic [1:0] x);
    return x == 2'd2 ? 2'd0 : x + 2'd1;
  endfunction
  assign unused_bits = ^pwdata19[6:5];
  assign elig = {1'b0, chan_intr19 & cfg_out19[3:1] & {3{cfg_out19[0]}}};
  // a disabling write aborts ASSERT/HOLD on the same edge it is written
  assign en_next = cfg_sel19 ? pwdata19[0] : cfg_out19[0];
  assign timeout = ACK_TIMEOUT != 8'd0 && ack_cnt == ACK_TIMEOUT - 8'd1;
  assign c0 = nxt(last_grant);
  assign c1 = nxt(c0);
  assign c2 = nxt(c1);
  assign grant = !cfg_out19[4] ? (elig[0] ? 2'd0 : elig[1] ? 2'd1 : 2'd2)
                               : (elig[c0] ? c0 : elig[c1] ? c1 : c2);
  assign irq19 = state == ASSERT;
  assign irq_id19 = irq19 ? id : 2'd0;
  assign clear_interrupt19 = state == CLEAR ? 3'b001 << id : 3'd0;
  always_ff @(posedge pclk19 or negedge n_p_reset19) begin
    if (!n_p_reset19) begin
      state          <= IDLE;
      id             <= 2'd0;
      last_grant     <= 2'd2;
      ack_cnt        <= 8'd0;
      hold_cnt       <= 3'd0;
      cfg_out19      <= 5'd0;
      timeout_flag19 <= 1'b0;
    end else begin
      if (cfg_sel19) cfg_out19 <= pwdata19[4:0];
      if (state == ASSERT && en_next && !ack19 && timeout) timeout_flag19 <= 1'b1;
      else if (cfg_sel19 && pwdata19[7]) timeout_flag19 <= 1'b0;
      case (state)
        IDLE:
          if (elig != 4'd0) begin
            state      <= ASSERT;
            id         <= grant;
            last_grant <= grant;
            ack_cnt    <= 8'd0;
          end
        ASSERT:
          if (!en_next) state <= IDLE;
          else if (ack19) state <= CLEAR;
          else if (timeout) state <= IDLE;
          else ack_cnt <= ack_cnt + 8'd1;
        CLEAR: begin
          state    <= HOLD;
          hold_cnt <= 3'(HOLDOFF - 1);
        end
        HOLD:
          if (!en_next || hold_cnt == 3'd0) state <= IDLE;
          else hold_cnt <= hold_cnt - 3'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ttc_intr_sched19.sv
// tb_ttc_intr_sched19: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the scheduler.
module tb_ttc_intr_sched19;
  localparam logic [7:0] TO = 8'd4;
  localparam int HO = 2;
  logic       pclk19 = 0, n_p_reset19 = 0, cfg_sel19 = 0, ack19 = 0;
  logic [2:0] chan_intr19 = 0;
  logic [7:0] pwdata19 = 0;
  logic       irq19, timeout_flag19;
  logic [1:0] irq_id19;
  logic [2:0] clear_interrupt19;
  logic [4:0] cfg_out19;
  int n_cmp = 0, n_fail = 0;

  ttc_intr_sched19 #(.ACK_TIMEOUT(TO), .HOLDOFF(HO)) dut (
    .pclk19(pclk19), .n_p_reset19(n_p_reset19), .chan_intr19(chan_intr19),
    .cfg_sel19(cfg_sel19), .pwdata19(pwdata19), .ack19(ack19), .irq19(irq19),
    .irq_id19(irq_id19), .clear_interrupt19(clear_interrupt19),
    .cfg_out19(cfg_out19), .timeout_flag19(timeout_flag19)
  );

  always #5 pclk19 = ~pclk19;

  // model: granted/clearing flags, ASSERT age, remaining hold cycles
  bit         m_irq = 0, m_clr = 0, m_flag = 0, en_now, t;
  int         m_id = 0, m_age = 0, m_hold = 0, m_last = 2;
  logic [4:0] m_cfg = 0;
  logic [2:0] m_elig;

  function automatic int pick(input logic [2:0] e, input bit rr, input int last);
    for (int k = 0; k < 3; k++) begin
      int c;
      c = rr ? (last + 1 + k) % 3 : k;
      if (e[c]) return c;
    end
    return 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge pclk19 or negedge n_p_reset19);
    if (!n_p_reset19) begin
      m_irq = 0; m_clr = 0; m_flag = 0; m_id = 0; m_age = 0; m_hold = 0; m_last = 2; m_cfg = 0;
    end else begin
      en_now = cfg_sel19 ? pwdata19[0] : m_cfg[0];
      m_elig = chan_intr19 & m_cfg[3:1] & {3{m_cfg[0]}};
      t = 0;
      if (m_irq) begin
        if (!en_now) m_irq = 0;
        else if (ack19) begin m_irq = 0; m_clr = 1; end
        else if (TO != 0 && m_age + 1 == int'(TO)) begin m_irq = 0; t = 1; end
        else m_age++;
      end else if (m_clr) begin
        m_clr = 0; m_hold = HO;
      end else if (m_hold > 0) begin
        m_hold = en_now ? m_hold - 1 : 0;
      end else if (m_elig != 0) begin
        m_id = pick(m_elig, m_cfg[4], m_last); m_last = m_id; m_irq = 1; m_age = 0;
      end
      if (t) m_flag = 1;
      else if (cfg_sel19 && pwdata19[7]) m_flag = 0;
      if (cfg_sel19) m_cfg = pwdata19[4:0];
    end
  end

  initial forever begin
    @(negedge pclk19);
    chk("irq", irq19, m_irq);
    chk("irq_id", irq_id19, m_irq ? m_id : 0);
    chk("clear", clear_interrupt19, m_clr ? (1 << m_id) : 0);
    chk("cfg_out", cfg_out19, m_cfg);
    chk("tflag", timeout_flag19, m_flag);
  end

  task automatic cyc(input logic [2:0] c, input logic s, input logic [7:0] d, input logic a);
    chan_intr19 = c; cfg_sel19 = s; pwdata19 = d; ack19 = a;
    @(negedge pclk19); #1;
  endtask

  int rr_exp[4] = '{0, 1, 2, 0};
  int w, hi;
  logic [7:0] d;

  initial begin
    @(negedge pclk19); #1;
    chk("rst_irq", irq19, 0); chk("rst_id", irq_id19, 0); chk("rst_clr", clear_interrupt19, 0);
    chk("rst_cfg", cfg_out19, 0); chk("rst_flag", timeout_flag19, 0);
    n_p_reset19 = 1;
    // fixed priority
    cyc(0, 1, 8'h0F, 0); chk("cfg_wr", cfg_out19, 5'h0F);
    cyc(3'b110, 0, 0, 0); chk("fx_irq", irq19, 1); chk("fx_id", irq_id19, 1);
    cyc(3'b110, 0, 0, 1); chk("fx_clr", clear_interrupt19, 3'b010);
    cyc(3'b100, 0, 0, 0); chk("fx_clr_end", clear_interrupt19, 0); chk("fx_hold1", irq19, 0);
    cyc(3'b100, 0, 0, 0); chk("fx_hold2", irq19, 0);
    cyc(3'b100, 0, 0, 0); chk("fx_idle", irq19, 0);
    cyc(3'b100, 0, 0, 0); chk("fx_rearb_irq", irq19, 1); chk("fx_rearb_id", irq_id19, 2);
    cyc(3'b100, 0, 0, 1); chk("fx_clr2", clear_interrupt19, 3'b100);
    repeat (3) cyc(0, 0, 0, 0);
    // round robin
    cyc(0, 1, 8'h1F, 0);
    for (int i = 0; i < 4; i++) begin
      w = 0;
      while (!irq19 && w < 10) begin cyc(3'b111, 0, 0, 0); w++; end
      chk("rr_wait", irq19, 1);
      chk("rr_id", irq_id19, rr_exp[i]);
      cyc(3'b111, 0, 0, 1); chk("rr_clr", clear_interrupt19, 1 << rr_exp[i]);
      cyc(3'b111, 0, 0, 0); chk("rr_clr_1cyc", clear_interrupt19, 0);
    end
    repeat (3) cyc(0, 0, 0, 0);
    // ack timeout
    cyc(0, 1, 8'h03, 0);
    cyc(3'b001, 0, 0, 0);
    hi = 0;
    while (irq19 && hi < 20) begin
      hi++;
      chk("to_noclr", clear_interrupt19, 0);
      cyc(3'b001, 0, 0, 0);
    end
    chk("to_hi_cycles", hi, 4); chk("to_flag", timeout_flag19, 1); chk("to_clr", clear_interrupt19, 0);
    cyc(0, 1, 8'h83, 0); chk("to_flag_clr", timeout_flag19, 0); chk("to_cfg", cfg_out19, 5'h03);
    // ack on the timeout edge
    cyc(3'b001, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1); chk("at_clr", clear_interrupt19, 3'b001); chk("at_flag", timeout_flag19, 0);
    repeat (3) cyc(0, 0, 0, 0);
    // disable during ASSERT
    cyc(3'b001, 0, 0, 0); chk("dis_pre", irq19, 1);
    cyc(3'b001, 1, 8'h00, 0); chk("dis_irq", irq19, 0); chk("dis_clr", clear_interrupt19, 0);
    repeat (4) begin
      cyc(3'b001, 0, 0, 0);
      chk("dis_nogrant", irq19, 0); chk("dis_noclr", clear_interrupt19, 0);
    end
    // reset during CLEAR
    cyc(0, 1, 8'h03, 0);
    cyc(3'b001, 0, 0, 0);
    cyc(3'b001, 0, 0, 1); chk("rc_clr", clear_interrupt19, 3'b001);
    #1 n_p_reset19 = 0;
    #1;
    chk("rc_clr0", clear_interrupt19, 0); chk("rc_irq", irq19, 0); chk("rc_id", irq_id19, 0);
    chk("rc_cfg", cfg_out19, 0); chk("rc_flag", timeout_flag19, 0);
    cyc(0, 0, 0, 0);
    n_p_reset19 = 1;
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 799) == 0) begin
        n_p_reset19 = 0; #2; n_p_reset19 = 1;
      end
      d = 8'($urandom);
      d[0] = $urandom_range(0, 4) != 0;
      cyc(3'($urandom_range(0, 7)), $urandom_range(0, 19) == 0, d, $urandom_range(0, 5) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ttc_intr_sched19.md
TTC_INTR_SCHED19 -- requirements
Module: ttc_intr_sched19

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 8'd200: maximum ASSERT cycles without acknowledge; 0 disables the timeout.
REQ-002 SHALL have parameter HOLDOFF, default 2: number of cycles to wait after a clear before re-arbitration (range 1..7).
REQ-003 pclk19  input  1  system clock; all state updates on the rising edge.
REQ-004 n_p_reset19  input  1  asynchronous, active-low reset.
REQ-005 chan_intr19  input  3  level interrupt from each of three timer-counter interrupt blocks; bit i is channel i.
REQ-006 cfg_sel19  input  1  config register write strobe, sampled on the clock edge.
REQ-007 pwdata19  input  8  write data: bit0 global enable; bits[3:1] channel enables for ch0..ch2; bit4 mode (0 fixed priority, 1 round-robin); bit7 write-1-clears timeout_flag19; bits 6:5 ignored.
REQ-008 ack19  input  1  CPU vector-read acknowledge, one-cycle pulse.
REQ-009 irq19  output  1  interrupt to CPU.
REQ-010 irq_id19  output  2  granted channel number; valid while irq19=1, otherwise 2'b00.
REQ-011 clear_interrupt19  output  3  one-hot, one-cycle clear pulse to the granted channel.
REQ-012 cfg_out19  output  5  config register readback: bits[4:0] of the last write.
REQ-013 timeout_flag19  output  1  sticky flag: an ASSERT ended by timeout.

Function
REQ-014 SHALL implement four states: IDLE, ASSERT, CLEAR, HOLD.
REQ-015 Eligible request vector = chan_intr19 & chan_en & {3{global_en}}.
REQ-016 IDLE: on an edge with eligible requests nonzero, latch the grant into the id register, clear the ack counter, go to ASSERT; otherwise stay in IDLE.
REQ-017 Fixed mode: the lowest channel index wins.
REQ-018 Round-robin mode: search starts at (last_grant+1) mod 3 and the first eligible channel wins.
REQ-019 last_grant is updated when entering ASSERT; its reset value is 2, so ch0 has first priority.
REQ-020 irq19 SHALL be 1 exactly while in ASSERT, i.e. it rises one cycle after the edge at which the request was sampled in IDLE.
REQ-021 ASSERT with ack19=1 at the edge: go to CLEAR.
REQ-022 In CLEAR, clear_interrupt19[id]=1 for exactly one cycle; all other bits stay 0.
REQ-023 CLEAR: go to HOLD and load the holdoff counter with HOLDOFF-1.
REQ-024 HOLD: decrement the counter each cycle and go to IDLE at count 0, so HOLD lasts HOLDOFF cycles. This lets the channel's interrupt register drop before re-arbitration.
REQ-025 ASSERT timeout: the 8-bit counter increments each cycle without ack. When the counter equals ACK_TIMEOUT-1 (ACK_TIMEOUT≠0): set timeout_flag19, go to IDLE with no clear pulse, and keep last_grant advanced so round-robin moves on.
REQ-026 ack19 and timeout in the same cycle: ack wins (CLEAR), and the flag is not set.
REQ-027 global_en written 0 while in ASSERT or HOLD: go to IDLE on the next edge, with no clear pulse.
REQ-028 global_en written 0 while in CLEAR: the clear pulse still completes.
REQ-029 A request withdrawn during ASSERT SHALL NOT deassert irq19; the grant holds until ack or timeout.
REQ-030 ack19 outside ASSERT SHALL be ignored.
REQ-031 Config write: the register updates at the edge and takes effect at the next IDLE arbitration; the id already latched is unaffected.
REQ-032 timeout_flag19 set and clear in the same cycle: set wins.
REQ-033 All outputs SHALL be registered or decoded from state only; there is no combinational path from inputs to outputs.

Reset
REQ-034 On n_p_reset19=0, the block SHALL immediately enter IDLE with: irq19=0, irq_id19=0, clear_interrupt19=0, cfg_out19=0, timeout_flag19=0, last_grant=2, counters=0.
REQ-035 Reset asserted mid-ASSERT or mid-CLEAR SHALL abort with no clear pulse. After release, the first arbitration is no earlier than the first rising edge.

Verification
REQ-036 Fixed mode, cfg=0x0F. At edge N: chan_intr19=3'b110. Required: irq19=1 and irq_id19=1 from N+1. ack at edge M: clear_interrupt19=3'b010 for cycle M+1 only. HOLD lasts 2 cycles, then re-arbitration grants ch2.
REQ-037 Round-robin, cfg=0x1F, all three requests held high with each serviced by ack. Required: grant order 0,1,2,0. Each clear pulse is one cycle.
REQ-038 ACK_TIMEOUT=4, cfg=0x03, ch0 requests, no ack. Required: irq19 high exactly 4 cycles, timeout_flag19=1, no clear pulse. A write of 0x83 clears the flag.
REQ-039 ack19 and timeout on the same edge. Required: clear pulse issued, timeout_flag19 stays 0.
REQ-040 A write of cfg=0x00 during ASSERT. Required: irq19=0 next cycle, no clear pulse, no further grants while requests are pending.
REQ-041 n_p_reset19 pulsed low during CLEAR. Required: clear_interrupt19 returns to 0 asynchronously and all outputs match the REQ-034 values.
